// File: rtl/jogo_sequencia_param.sv
// jogo_sequencia_param: parametrised sequence-memory game core with growing rounds,
// one-hot expected plays generated arithmetically and a per-play timeout.
`default_nettype none

module jogo_sequencia_param #(
    parameter int N_CHAVES       = 4,
    parameter int PROF           = 16,
    parameter int PASSO          = 1,
    parameter int TIMEOUT_CICLOS = 5000,
    localparam int W             = $clog2(PROF)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic [N_CHAVES-1:0] chaves,
    output logic                pronto,
    output logic                acertou,
    output logic                errou,
    output logic                timeout,
    output logic [N_CHAVES-1:0] leds,
    output logic                db_igual,
    output logic [3:0]          db_estado,
    output logic [W-1:0]        db_contagem,
    output logic [W-1:0]        db_rodada
);

    localparam int TW = $clog2(TIMEOUT_CICLOS);

    typedef enum logic [3:0] {
        ST_INICIAL        = 4'h0,
        ST_PREPARACAO     = 4'h1,
        ST_ESPERA         = 4'h2,
        ST_REGISTRA       = 4'h3,
        ST_COMPARA        = 4'h4,
        ST_PROXIMA        = 4'h5,
        ST_PROXIMA_RODADA = 4'h6,
        ST_FIM_ACERTO     = 4'hA,
        ST_FIM_TIMEOUT    = 4'hD,
        ST_FIM_ERRO       = 4'hE
    } estado_t;

    estado_t             estado;
    logic [W-1:0]        endereco;
    logic [W-1:0]        rodada;
    logic [TW-1:0]       contador;
    logic [N_CHAVES-1:0] registrador;
    logic [N_CHAVES-1:0] chaves_d;
    logic [N_CHAVES-1:0] esperado;
    logic [31:0]         indice;
    logic                jogada;
    logic                igual;

    assign indice   = (32'(endereco) * 32'(PASSO)) % 32'(N_CHAVES);
    assign esperado = N_CHAVES'(1) << indice;
    assign igual    = (registrador == esperado);

    // Rising edge of "any switch up": a held switch counts only once.
    assign jogada = (|chaves) & ~(|chaves_d);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado      <= ST_INICIAL;
            endereco    <= '0;
            rodada      <= '0;
            contador    <= '0;
            registrador <= '0;
            chaves_d    <= '0;
        end else begin
            chaves_d <= chaves;
            case (estado)
                ST_INICIAL: begin
                    if (iniciar) estado <= ST_PREPARACAO;
                end
                ST_PREPARACAO: begin
                    endereco    <= '0;
                    rodada      <= '0;
                    contador    <= '0;
                    registrador <= '0;
                    estado      <= ST_ESPERA;
                end
                ST_ESPERA: begin
                    // A play on the last allowed cycle takes priority over the timeout.
                    if (jogada) begin
                        registrador <= chaves;
                        estado      <= ST_REGISTRA;
                    end else if (contador == TW'(TIMEOUT_CICLOS - 1)) begin
                        estado <= ST_FIM_TIMEOUT;
                    end else begin
                        contador <= contador + TW'(1);
                    end
                end
                ST_REGISTRA: begin
                    contador <= '0;
                    estado   <= ST_COMPARA;
                end
                ST_COMPARA: begin
                    if (!igual)                          estado <= ST_FIM_ERRO;
                    else if (endereco != rodada)         estado <= ST_PROXIMA;
                    else if (rodada == W'(PROF - 1))     estado <= ST_FIM_ACERTO;
                    else                                 estado <= ST_PROXIMA_RODADA;
                end
                ST_PROXIMA: begin
                    endereco <= endereco + W'(1);
                    estado   <= ST_ESPERA;
                end
                ST_PROXIMA_RODADA: begin
                    rodada   <= rodada + W'(1);
                    endereco <= '0;
                    estado   <= ST_ESPERA;
                end
                ST_FIM_ACERTO, ST_FIM_ERRO, ST_FIM_TIMEOUT: begin
                    if (iniciar) estado <= ST_PREPARACAO;
                end
                default: estado <= ST_INICIAL;
            endcase
        end
    end

    assign pronto      = (estado == ST_FIM_ACERTO) || (estado == ST_FIM_ERRO) ||
                         (estado == ST_FIM_TIMEOUT);
    assign acertou     = (estado == ST_FIM_ACERTO);
    assign errou       = (estado == ST_FIM_ERRO) || (estado == ST_FIM_TIMEOUT);
    assign timeout     = (estado == ST_FIM_TIMEOUT);
    assign leds        = registrador;
    assign db_igual    = igual;
    assign db_estado   = estado;
    assign db_contagem = endereco;
    assign db_rodada   = rodada;

endmodule

`default_nettype wire
